// File: rtl/tile_row_packer.sv
// rtl/tile_row_packer.sv - assembles 8-element row beats into ping-pong banked 64-element tiles
module tile_row_packer #(
  parameter int DATA_WIDTH = 16,
  parameter int ROWS       = 8,
  parameter int COLS       = 8
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [COLS*DATA_WIDTH-1:0]      row_data,
  input  logic                            row_valid,
  input  logic                            row_last,
  output logic                            row_ready,
  output logic [ROWS*COLS*DATA_WIDTH-1:0] tile_data,
  output logic [$clog2(ROWS+1)-1:0]       tile_rows,
  output logic                            tile_valid,
  input  logic                            tile_ready
);
  localparam int CW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int RW = $clog2(ROWS + 1);
  localparam int TE = ROWS * COLS;
  localparam logic [CW-1:0] LAST_ROW = CW'(ROWS - 1);

  logic [DATA_WIDTH-1:0] mem [2][TE];
  logic [1:0]            full;
  logic [RW-1:0]         nrows [2];
  logic                  wr_ptr;
  logic                  rd_ptr;
  logic [CW-1:0]         row_cnt;
  logic                  row_acc;
  logic                  tile_close;
  logic                  tile_rel;

  // Only flops feed row_ready, so tile_ready never reaches it combinationally.
  assign row_ready  = !full[wr_ptr];
  assign row_acc    = row_valid && row_ready;
  assign tile_close = row_acc && (row_last || row_cnt == LAST_ROW);
  assign tile_valid = full[rd_ptr];
  assign tile_rel   = tile_valid && tile_ready;
  assign tile_rows  = nrows[rd_ptr];

  for (genvar e = 0; e < TE; e++) begin : g_out
    assign tile_data[e*DATA_WIDTH +: DATA_WIDTH] = mem[rd_ptr][e];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int b = 0; b < 2; b++) begin
        for (int e = 0; e < TE; e++) begin
          mem[b][e] <= '0;
        end
        nrows[b] <= '0;
      end
      full    <= '0;
      wr_ptr  <= 1'b0;
      rd_ptr  <= 1'b0;
      row_cnt <= '0;
    end else begin
      if (row_acc) begin
        // Rows past the closing row are zeroed so stale data from the bank's previous tile never leaks.
        for (int r = 0; r < ROWS; r++) begin
          for (int c = 0; c < COLS; c++) begin
            if (CW'(r) == row_cnt) begin
              mem[wr_ptr][r*COLS+c] <= row_data[c*DATA_WIDTH +: DATA_WIDTH];
            end else if (tile_close && CW'(r) > row_cnt) begin
              mem[wr_ptr][r*COLS+c] <= '0;
            end
          end
        end
        if (tile_close) begin
          full[wr_ptr]  <= 1'b1;
          nrows[wr_ptr] <= RW'(row_cnt) + RW'(1);
          wr_ptr        <= !wr_ptr;
          row_cnt       <= '0;
        end else begin
          row_cnt <= row_cnt + CW'(1);
        end
      end
      // Close needs the write bank empty and release needs the read bank full, so they never collide.
      if (tile_rel) begin
        full[rd_ptr] <= 1'b0;
        rd_ptr       <= !rd_ptr;
      end
    end
  end
endmodule

// File: tb/tb_tile_row_packer.sv
// tb/tb_tile_row_packer.sv - randomized bench for tile_row_packer against a tile-FIFO model
module tb_tile_row_packer;
  localparam int DW   = 16;
  localparam int ROWS = 8;
  localparam int COLS = 8;
  localparam int RB   = COLS * DW;
  localparam int TW   = ROWS * RB;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [RB-1:0] row_data = '0;
  logic          row_valid = 1'b0;
  logic          row_last = 1'b0;
  logic          row_ready;
  logic [TW-1:0] tile_data;
  logic [3:0]    tile_rows;
  logic          tile_valid;
  logic          tile_ready = 1'b0;

  int total = 0;
  int bad = 0;

  tile_row_packer #(.DATA_WIDTH(DW), .ROWS(ROWS), .COLS(COLS)) dut (
    .clk(clk), .rst_n(rst_n), .row_data(row_data), .row_valid(row_valid),
    .row_last(row_last), .row_ready(row_ready), .tile_data(tile_data),
    .tile_rows(tile_rows), .tile_valid(tile_valid), .tile_ready(tile_ready)
  );

  always #5 clk = ~clk;

  // Model: completed tiles awaiting handover, plus the tile being assembled.
  logic [TW-1:0] exp_q[$];
  int            rows_q[$];
  logic [TW-1:0] cur = '0;
  int            cnt = 0;
  int            tiles_out = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q.delete();
      rows_q.delete();
      cur = '0;
      cnt = 0;
    end else begin
      bit acc, rel;
      acc = row_valid && (exp_q.size() < 2);
      rel = tile_ready && (exp_q.size() > 0);
      if (rel) begin
        void'(exp_q.pop_front());
        void'(rows_q.pop_front());
        tiles_out++;
      end
      if (acc) begin
        cur[cnt*RB +: RB] = row_data;
        cnt++;
        if (row_last || cnt == ROWS) begin
          exp_q.push_back(cur);
          rows_q.push_back(cnt);
          cur = '0;
          cnt = 0;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_tile(input string name, input logic [TW-1:0] act, input logic [TW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      for (int e = 0; e < ROWS * COLS; e++) begin
        if (act[e*DW +: DW] !== exp[e*DW +: DW]) begin
          $display("FAIL %s: element %0d got %h expected %h at %0t", name, e,
                   act[e*DW +: DW], exp[e*DW +: DW], $time);
          break;
        end
      end
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      chk("row_ready", 32'(row_ready), 32'(exp_q.size() < 2));
      chk("tile_valid", 32'(tile_valid), 32'(exp_q.size() > 0));
      if (exp_q.size() > 0) begin
        chk_tile("tile_data", tile_data, exp_q[0]);
        chk("tile_rows", 32'(tile_rows), 32'(rows_q[0]));
      end
    end
  end

  function automatic logic [DW-1:0] elem(input int r, input int c);
    return tile_data[(r*COLS+c)*DW +: DW];
  endfunction

  function automatic logic [RB-1:0] rnd_row();
    logic [RB-1:0] v;
    for (int i = 0; i < RB / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  function automatic logic [RB-1:0] seq_row(input int r);
    logic [RB-1:0] v;
    for (int c = 0; c < COLS; c++) v[c*DW +: DW] = DW'(r * COLS + c);
    return v;
  endfunction

  // Entered and left at 1 time unit after a rising edge.
  task automatic send_row(input logic [RB-1:0] d, input logic last);
    int w = 0;
    row_valid = 1'b1;
    row_data  = d;
    row_last  = last;
    @(negedge clk);
    while (!row_ready && w < 200) begin
      w++;
      @(negedge clk);
    end
    if (w >= 200) begin
      total++;
      bad++;
      $display("FAIL row_accept_timeout: row_ready stuck at %b, required 1", row_ready);
    end
    @(posedge clk);
    #1;
    row_valid = 1'b0;
    row_last  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_state();
    chk("rst_row_ready", 32'(row_ready), 32'd1);
    chk("rst_tile_valid", 32'(tile_valid), 32'd0);
    chk("rst_tile_rows", 32'(tile_rows), 32'd0);
    chk_tile("rst_tile_data", tile_data, '0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [TW-1:0] snap;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_state();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(1);

    // Full tile, fast sink
    tile_ready = 1'b1;
    for (int r = 0; r < ROWS; r++) send_row(seq_row(r), 1'b0);
    @(negedge clk);
    chk("t1_valid", 32'(tile_valid), 32'd1);
    chk("t1_rows", 32'(tile_rows), 32'd8);
    chk("t1_e35", 32'(elem(3, 5)), 32'd29);
    chk("t1_e77", 32'(elem(7, 7)), 32'd63);
    idle(2);

    // Short tiles; the second lands in the bank still holding the first full tile
    for (int k = 0; k < 2; k++) begin
      for (int r = 0; r < 3; r++) send_row({COLS{16'hAAAA}}, r == 2);
      if (k == 1) begin
        @(negedge clk);
        chk("t2_rows", 32'(tile_rows), 32'd3);
        chk("t2_e27", 32'(elem(2, 7)), 32'hAAAA);
        chk("t2_e30", 32'(elem(3, 0)), 32'd0);
        chk("t2_e77", 32'(elem(7, 7)), 32'd0);
      end
      idle(2);
    end

    // Back-pressure: two tiles buffered, third waits
    tile_ready = 1'b0;
    for (int r = 0; r < 2 * ROWS; r++) send_row(rnd_row(), 1'b0);
    @(negedge clk);
    chk("bp_row_ready", 32'(row_ready), 32'd0);
    snap = tile_data;
    repeat (4) @(negedge clk);
    chk_tile("bp_stable", tile_data, snap);
    @(posedge clk);
    #1;
    tile_ready = 1'b1;
    for (int r = 0; r < ROWS; r++) send_row(rnd_row(), 1'b0);
    idle(4);

    // Close of tile 1 coincides with release of tile 0
    tile_ready = 1'b0;
    for (int r = 0; r < 2 * ROWS - 1; r++) send_row(rnd_row(), 1'b0);
    tile_ready = 1'b1;
    send_row(rnd_row(), 1'b0);
    @(negedge clk);
    chk("sim_valid", 32'(tile_valid), 32'd1);
    chk("sim_row_ready", 32'(row_ready), 32'd1);
    idle(3);

    // Reset in the middle of a tile
    for (int r = 0; r < 5; r++) send_row(rnd_row(), 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    chk_reset_state();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tiles_out = 0;
    for (int r = 0; r < ROWS; r++) send_row(seq_row(r + 1), 1'b0);
    @(negedge clk);
    chk("rst_fresh_rows", 32'(tile_rows), 32'd8);
    chk("rst_fresh_e00", 32'(elem(0, 0)), 32'd8);
    idle(2);
    chk("rst_fresh_count", 32'(tiles_out), 32'd1);

    // Random valid/last/ready traffic
    for (int i = 0; i < 1000; i++) begin
      row_valid  = ($urandom_range(0, 3) != 0);
      row_last   = ($urandom_range(0, 4) == 0);
      row_data   = rnd_row();
      tile_ready = ($urandom_range(0, 2) != 0);
      @(posedge clk);
      #1;
    end
    row_valid  = 1'b0;
    row_last   = 1'b0;
    tile_ready = 1'b1;
    idle(6);
    @(negedge clk);
    chk("drain_empty", 32'(tile_valid), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/tile_row_packer.md
Name: tile_row_packer

Overview:
- Upstream feeder for the 8x8 transpose stage.
- Accepts activation/weight rows as 8-element beats from the on-chip buffer read path and assembles them into a complete 64-element tile, presented in parallel with a valid/ready handshake.
- Two ping-pong tile banks let row streaming for tile N+1 overlap with the downstream stage holding tile N.

Parameters:
- DATA_WIDTH, 16, bits per element.
- ROWS, 8, rows per tile.
- COLS, 8, elements per row.

Ports:
- clk  input  1  clock.
- rst_n  input  1  reset.
- row_data  input  COLS*DATA_WIDTH  one row; element c at bits [c*DATA_WIDTH +: DATA_WIDTH].
- row_valid  input  1  row beat valid.
- row_last  input  1  final row of the current tile; qualified by row_valid.
- row_ready  output  1  packer can accept a row this cycle.
- tile_data  output  ROWS*COLS*DATA_WIDTH  tile, row-major; element (r,c) at index r*COLS+c.
- tile_rows  output  $clog2(ROWS+1)  number of real rows in the presented tile (1..ROWS).
- tile_valid  output  1  tile_data is a complete tile.
- tile_ready  input  1  downstream accepts the tile.

Behaviour:
- Reset: rst_n is asynchronous, active-low; clock is clk.
  - All bank storage is cleared to 0; tile_data=0, tile_rows=0, tile_valid=0, row_ready=1.
  - Write bank = 0, read bank = 0, row counter = 0, both bank-full flags = 0.
- Banks: two banks B0/B1, each ROWS*COLS elements, with full flag F[b] and row count N[b].
  - wr_ptr selects the filling bank; rd_ptr selects the presented bank.
- Row accept: a beat is accepted when row_valid && row_ready.
  - row_data is written into row row_cnt of bank wr_ptr, then row_cnt increments.
- Tile close: the tile closes on an accepted beat with row_last=1, or when row_cnt==ROWS-1 (ROWS-th row), whichever comes first.
  - On close: remaining rows of that bank are zero-filled in the same cycle, N[wr_ptr] = accepted row count, F[wr_ptr] set, wr_ptr toggles, row_cnt cleared.
  - row_last on the ROWS-th row closes the tile once, not twice.
- row_ready = !F[wr_ptr], registered-equivalent with no combinational path from tile_ready.
  - row_ready is low only while both banks are full.
- Output: tile_valid = F[rd_ptr]; tile_data and tile_rows are driven from bank rd_ptr.
  - On tile_valid && tile_ready: F[rd_ptr] cleared, rd_ptr toggles.
  - tile_data stays stable while tile_valid=1 and tile_ready=0.
- Latency: tile_valid rises the cycle after the closing row is accepted (1 cycle). Sustained throughput is 1 row/cycle when downstream accepts within ROWS cycles.
- Simultaneous close and release: tile close on bank A and a tile_ready handshake on bank B in the same cycle are both honoured.
  - tile_valid stays high, presenting bank A the next cycle.
- Close into a just-released bank: if the write bank was freed by a handshake this cycle, row_ready reflects it the next cycle (no same-cycle bypass).
- Beats without row_valid: row_last is ignored.
- Reset mid-tile: partially filled and full banks are discarded, with no output of partial data.
- Arithmetic: row_cnt width is $clog2(ROWS); it never wraps past ROWS-1 because the tile closes at ROWS-1.

Test Plan:
- Full tile, fast sink: 8 rows with element (r,c)=r*8+c, tile_ready=1 -> tile_valid 1 cycle after row 7; tile_data[r*8+c]=r*8+c; tile_rows=8.
- Short tile: 3 rows of 0xAAAA with row_last on row 2 -> tile_rows=3; rows 0-2 = 0xAAAA; rows 3-7 = 0.
- Back-pressure: tile_ready=0, stream 24 rows -> two tiles buffered; row_ready=0 after row 16 is accepted; tile_data is stable; releasing tile_ready drains bank 0 then bank 1 in order.
- Simultaneous close and release: tile 0 presented, tile_ready asserted on the cycle row 7 of tile 1 is accepted -> tile 1 valid on the next cycle with no bubble; no rows dropped.
- Reset mid-operation: assert rst_n=0 after 5 rows of a tile, then 8 fresh rows -> only the fresh tile appears; tile_rows=8; no zero/stale data emitted.
- Random valid/ready: 1000 random row_valid/row_last/tile_ready patterns checked against a reference FIFO model -> all tiles match in order; no handshake violations.
